dna_gene_fetcher: RTL and testbench

//  Downstream consumer of the DNA written to RAM during randomization. On start, reads the gene

---
 rtl/dna_gene_fetcher.sv | 133 +++++++++++++
 tb/tb_dna_gene_fetcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_gene_fetcher.sv
// dna_gene_fetcher: reads one network's genes from shared RAM into a prefetch FIFO and streams them out.
// Optional macro GENE_RANGE_CHECK_EN zeroes out-of-range genes and raises a sticky gene_err.
module dna_gene_fetcher #(
  parameter int OUTPUT_COUNT = 1,
  parameter int NEURON_COUNT = 2,
  parameter int CONNECTIONS = 2,
  parameter int NETWORKS_PER_POPULATION = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LOAD_STATE = 1,
  localparam int GENES = OUTPUT_COUNT + NEURON_COUNT * CONNECTIONS,
  localparam int NET_W = $clog2(NETWORKS_PER_POPULATION)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       network_state,
  input  logic             start,
  input  logic [NET_W-1:0] net_index,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [15:0]      gene_data,
  output logic [7:0]       gene_index,
  output logic             gene_valid,
  input  logic             gene_ready,
  output logic             gene_err,
  inout  wire  [15:0]      ram_bus_data,
  inout  wire  [22:0]      ram_bus_addr,
  inout  wire              ram_latch,
  input  logic             ram_ready,
  inout  wire              ram_instruction
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ISS_W = $clog2(GENES + 1);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
  state_t           r_state, w_next;
  logic [22:0]      r_base, r_addr;
  logic [ISS_W-1:0] r_issued;
  logic [7:0]       r_idx;
  logic             r_latch, r_seen_low, r_done, r_aborted;
  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd, r_wr;
  logic [CNT_W-1:0] r_count;
  logic             w_own, w_busy, w_abort, w_start, w_pop, w_issue, w_push, w_last, w_fin;
  logic [15:0]      w_wdata;
  assign w_own   = network_state == 2'(LOAD_STATE);
  assign w_busy  = r_state != S_IDLE;
  assign w_abort = w_busy && !w_own;
  assign w_start = r_state == S_IDLE && start && w_own;
  assign w_pop   = gene_valid && gene_ready;
  assign w_issue = r_state == S_REQ && w_own && ram_ready && r_count < CNT_W'(FIFO_DEPTH)
                   && r_issued < ISS_W'(GENES);
  assign w_push  = r_state == S_WAIT && ram_ready && r_seen_low && !w_abort;
  assign w_last  = r_issued == ISS_W'(GENES - 1);
  assign w_fin   = r_state == S_DRAIN && w_pop && r_count == CNT_W'(1);
`ifdef GENE_RANGE_CHECK_EN
  localparam int MAX_GENE = OUTPUT_COUNT + NEURON_COUNT + 1;
  logic w_bad, r_err;
  assign w_bad   = ram_bus_data >= 16'(MAX_GENE);
  assign w_wdata = w_bad ? '0 : ram_bus_data;
  assign gene_err = r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else if (w_start) r_err <= 1'b0;
    else if (w_push && w_bad) r_err <= 1'b1;
`else
  assign w_wdata  = ram_bus_data;
  assign gene_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = S_IDLE;
    else if (w_start) w_next = S_REQ;
    else if (w_issue) w_next = S_WAIT;
    else if (w_push) w_next = w_last ? S_DRAIN : S_REQ;
    else if (w_fin) w_next = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_addr     <= '0;
      r_issued   <= '0;
      r_idx      <= '0;
      r_latch    <= 1'b0;
      r_seen_low <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_fin && !w_abort;
      r_aborted  <= w_abort;
      r_latch    <= w_issue;
      r_seen_low <= w_issue ? 1'b0 : (r_seen_low | (r_state == S_WAIT && !ram_ready));
      if (w_issue) r_addr <= r_base + 23'(r_issued);
      if (w_start) begin
        r_base   <= 23'(net_index) * 23'(GENES);
        r_issued <= '0;
        r_idx    <= '0;
      end
      if (w_abort) begin
        r_rd    <= '0;
        r_wr    <= '0;
        r_count <= '0;
        r_idx   <= '0;
      end else begin
        if (w_push) begin
          r_wr     <= r_wr + PTR_W'(1);
          r_issued <= r_issued + ISS_W'(1);
        end
        if (w_pop) begin
          r_rd  <= r_rd + PTR_W'(1);
          r_idx <= r_idx + 8'd1;
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= w_wdata;
  assign busy       = w_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign gene_valid = r_count != '0;
  assign gene_data  = gene_valid ? r_mem[r_rd] : '0;
  assign gene_index = r_idx;
  // Bus release follows network_state directly so ownership is dropped in the same cycle.
  assign ram_bus_addr    = w_own ? r_addr : 23'bz;
  assign ram_latch       = w_own ? r_latch : 1'bz;
  assign ram_instruction = w_own ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_dna_gene_fetcher.sv
// tb_dna_gene_fetcher: randomized RAM/consumer stimulus checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_dna_gene_fetcher;
`ifdef GENE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int GENES = 5;
  localparam int LIMIT = 4;
  logic clk = 0, rst_n = 0, start = 0, gene_ready = 0, ram_ready = 1;
  logic [1:0] network_state = 2'd1;
  logic [3:0] net_index = 0;
  logic busy, done, aborted, gene_valid, gene_err;
  logic [15:0] gene_data;
  logic [7:0] gene_index;
  wire [15:0] ram_bus_data;
  wire [22:0] ram_bus_addr;
  wire ram_latch, ram_instruction;
  logic [15:0] ram_q = 0;
  logic [15:0] ram [128];
  int checks = 0, errors = 0;
  bit m_active, m_exp_done, m_exp_abort, bad_all, rnd_mode;
  int m_base, m_nl, m_np, n_done, n_abort;
  int exp_w [GENES];
  bit bad [GENES];
  int got_q [$];
  int lat_q [$];
  bit p_valid, p_ready;
  int p_data, p_idx;
  assign ram_bus_data = ram_q;
  pullup (ram_latch);
  pullup (ram_instruction);
  always #5 clk = ~clk;
  dna_gene_fetcher dut (
    .clk(clk), .rst_n(rst_n), .network_state(network_state), .start(start), .net_index(net_index),
    .busy(busy), .done(done), .aborted(aborted), .gene_data(gene_data), .gene_index(gene_index),
    .gene_valid(gene_valid), .gene_ready(gene_ready), .gene_err(gene_err), .ram_bus_data(ram_bus_data),
    .ram_bus_addr(ram_bus_addr), .ram_latch(ram_latch), .ram_ready(ram_ready),
    .ram_instruction(ram_instruction)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // RAM: accepts a strobe, drops ready for 1-3 cycles, then presents the word with ready high.
  initial begin
    int a;
    forever begin
      @(negedge clk);
      if (rst_n && network_state == 2'd1 && ram_latch && ram_ready) begin
        a = int'(ram_bus_addr) % 128;
        ram_ready = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        ram_q = ram[a];
        ram_ready = 1;
      end
    end
  end
  always @(negedge clk) begin
    bit own, hs, bad_upto;
    int w;
    if (!rst_n) begin
      m_active = 0; m_exp_done = 0; m_exp_abort = 0; p_valid = 0;
    end else begin
      own = network_state == 2'd1;
      hs = gene_valid && gene_ready;
      chk("done", done, m_exp_done);
      chk("aborted", aborted, m_exp_abort);
      chk("busy", busy, m_active);
      if (done) n_done++;
      if (aborted) n_abort++;
      if (!m_active) chk("valid_idle", gene_valid, 0);
      if (!own) begin
        chk("latch_z", ram_latch, 1);
        chk("instr_z", ram_instruction, 1);
      end else begin
        chk("instr_read", ram_instruction, 0);
        if (ram_latch) begin
          chk("latch_active", m_active, 1);
          chk("latch_addr", ram_bus_addr, m_base + m_nl);
          chk("latch_count", m_nl < GENES, 1);
          chk("fifo_room", m_nl - m_np <= 4, 1);
          lat_q.push_back(int'(ram_bus_addr));
          m_nl++;
        end
      end
      if (p_valid && !p_ready && gene_valid && m_active) begin
        chk("hold_data", gene_data, p_data);
        chk("hold_idx", gene_index, p_idx);
      end
      if (hs && m_active && m_np < GENES) begin
        chk("gene_idx", gene_index, m_np);
        chk("gene_data", gene_data, exp_w[m_np]);
        bad_upto = 0;
        for (int k = 0; k <= m_np; k++) bad_upto |= bad[k];
        if (bad_upto || !bad_all) chk("gene_err", gene_err, bad_upto);
        got_q.push_back(int'(gene_data));
        m_np++;
      end
      m_exp_done = 0;
      m_exp_abort = 0;
      if (m_active && !own) begin
        m_active = 0; m_exp_abort = 1;
      end else if (m_active && m_np == GENES) begin
        m_active = 0; m_exp_done = 1;
      end else if (!m_active && start && own) begin
        m_active = 1; m_nl = 0; m_np = 0; bad_all = 0;
        m_base = int'(net_index) * GENES;
        for (int k = 0; k < GENES; k++) begin
          w = int'(ram[m_base + k]);
          bad[k] = RC && w >= LIMIT;
          exp_w[k] = bad[k] ? 0 : w;
          bad_all |= bad[k];
        end
      end
      p_valid = gene_valid; p_ready = gene_ready; p_data = gene_data; p_idx = gene_index;
    end
  end
  int base_end;
  task automatic begin_fetch(input int n);
    got_q.delete();
    lat_q.delete();
    base_end = n_done + n_abort;
    @(posedge clk); #1;
    net_index = 4'(n); start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic finish_fetch(input bit do_abort, input int ab_at);
    int c;
    c = 0;
    while (n_done + n_abort == base_end && c < 1000) begin
      @(posedge clk); #1;
      c++;
      if (rnd_mode) gene_ready = ($urandom % 3) != 0;
      if (do_abort && c == ab_at) network_state = 2'd0;
      if (c == ab_at + 2) network_state = 2'd1;
    end
    chk("fetch_end", n_done + n_abort - base_end, 1);
    if (network_state != 2'd1) begin
      @(posedge clk); #1;
      network_state = 2'd1;
    end
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
    chk({tag, "_valid"}, gene_valid, 0);
    chk({tag, "_data"}, gene_data, 0);
    chk({tag, "_index"}, gene_index, 0);
    chk({tag, "_err"}, gene_err, 0);
    chk({tag, "_latch"}, ram_latch, 0);
  endtask
  initial begin
    int nd, c;
    int t1 [GENES] = '{1, 2, 0, 3, 1};
    int t4 [GENES] = '{3, 0, 2, 1, 3};
    for (int i = 0; i < 128; i++) ram[i] = 0;
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset");
    rst_n = 1;
    for (int k = 0; k < GENES; k++) ram[15 + k] = 16'(t1[k]);
    // basic fetch of network 3
    gene_ready = 1;
    nd = n_done;
    begin_fetch(3);
    finish_fetch(0, 0);
    chk("t1_done_count", n_done - nd, 1);
    chk("t1_genes", got_q.size(), GENES);
    chk("t1_addrs", lat_q.size(), GENES);
    for (int k = 0; k < GENES; k++) begin
      if (k < got_q.size()) chk("t1_gene_lit", got_q[k], t1[k]);
      if (k < lat_q.size()) chk("t1_addr_lit", lat_q[k], 15 + k);
    end
    // consumer stalled: FIFO fills to four then requests stop
    gene_ready = 0;
    begin_fetch(3);
    repeat (60) @(posedge clk);
    @(negedge clk); #1;
    chk("t2_latches", lat_q.size(), 4);
    chk("t2_valid", gene_valid, 1);
    chk("t2_head", gene_data, 1);
    chk("t2_index", gene_index, 0);
    @(posedge clk); #1;
    gene_ready = 1;
    finish_fetch(0, 0);
    chk("t2_genes", got_q.size(), GENES);
    for (int k = 0; k < GENES && k < got_q.size(); k++) chk("t2_gene_lit", got_q[k], t1[k]);
    // abort after two genes popped
    nd = n_done;
    begin_fetch(3);
    c = 0;
    while (m_np < 2 && c < 300) begin
      @(negedge clk); #1;
      c++;
    end
    chk("t3_reached", m_np >= 2, 1);
    @(posedge clk); #1;
    network_state = 2'd0;
    #1;
    chk("t3_latch_z", ram_latch, 1);
    chk("t3_instr_z", ram_instruction, 1);
    @(posedge clk); #1;
    chk("t3_aborted", aborted, 1);
    chk("t3_valid", gene_valid, 0);
    chk("t3_busy", busy, 0);
    @(posedge clk); #1;
    chk("t3_abort_pulse", aborted, 0);
    network_state = 2'd1;
    repeat (3) @(posedge clk);
    chk("t3_no_done", n_done - nd, 0);
    // reset while waiting on RAM, then a clean fetch of network 0
    for (int k = 0; k < GENES; k++) ram[k] = 16'(t4[k]);
    begin_fetch(5);
    c = 0;
    while (m_nl < 1 && c < 300) begin
      @(negedge clk); #1;
      c++;
    end
    @(posedge clk); #3;
    rst_n = 0;
    #1 chk_outputs_zero("t4_async");
    @(posedge clk); #1;
    rst_n = 1;
    begin_fetch(0);
    finish_fetch(0, 0);
    chk("t4_genes", got_q.size(), GENES);
    for (int k = 0; k < GENES && k < got_q.size(); k++) chk("t4_gene_lit", got_q[k], t4[k]);
    for (int k = 0; k < GENES && k < lat_q.size(); k++) chk("t4_addr_lit", lat_q[k], k);
    // start pulsed while busy must not disturb the current fetch
    for (int k = 0; k < GENES; k++) ram[35 + k] = 16'(k + 1);
    begin_fetch(7);
    repeat (3) @(posedge clk);
    #1 net_index = 4'd2; start = 1;
    @(posedge clk); #1;
    start = 0;
    finish_fetch(0, 0);
    chk("t5_addrs", lat_q.size(), GENES);
    for (int k = 0; k < GENES && k < lat_q.size(); k++) chk("t5_addr_lit", lat_q[k], 35 + k);
    // out-of-range gene word
    ram[45] = 2; ram[46] = 9; ram[47] = 1; ram[48] = 0; ram[49] = 3;
    begin_fetch(9);
    finish_fetch(0, 0);
    chk("t6_genes", got_q.size(), GENES);
    if (got_q.size() > 1) chk("t6_gene1", got_q[1], RC ? 0 : 9);
    chk("t6_err", gene_err, RC);
    for (int k = 0; k < GENES; k++) ram[5 + k] = 16'(k % 4);
    begin_fetch(1);
    @(negedge clk); #1;
    chk("t6_err_cleared", gene_err, 0);
    finish_fetch(0, 0);
    // randomized fetches with random consumer stalls and occasional aborts
    rnd_mode = 1;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 80; i++) ram[i] = 16'($urandom_range(0, 9));
      begin_fetch($urandom_range(0, 15));
      finish_fetch(($urandom % 4) == 0, $urandom_range(1, 40));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rnd_mode = 0;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
